// File: rtl/alarm_controller.sv
// ----------------------------------------------------------------------------
// alarm_controller
//
// Sequences an alarm event: watches the running time against the stored
// alarm time, rings the buzzer on the rising edge of a match, and handles
// stop, snooze and automatic time-out. All intervals are paced by the
// system 1 Hz tick.
//
// Optional feature macro: ALARM_SNOOZE_EN
//   defined   - SNOOZE state, snooze counting and the snoozing output exist
//   undefined - snooze_p is ignored; snoozing and snooze_count read 0
//
// Parameters:
//   RING_SECONDS   seconds the alarm rings before auto time-out
//   SNOOZE_SECONDS silent interval after a snooze
//   MAX_SNOOZES    snoozes allowed per alarm event (1..3)
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   tick_1hz      one-clk pulse per second
//   cur_hour/min/sec   running time
//   alarm_hour/min     stored alarm time
//   alarm_armed   level, alarm function enabled
//   snooze_p      one-cycle snooze request
//   stop_p        one-cycle stop request
//   buzzer_en     buzzer enable (high while ringing)
//   ringing       high in RINGING
//   snoozing      high in SNOOZE
//   snooze_count  snoozes used in the current event
//   alarm_missed  sticky, set when ringing ended by time-out
// ----------------------------------------------------------------------------
module alarm_controller #(
    parameter int unsigned RING_SECONDS   = 60,
    parameter int unsigned SNOOZE_SECONDS = 300,
    parameter int unsigned MAX_SNOOZES    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    input  logic [4:0] alarm_hour,
    input  logic [5:0] alarm_min,
    input  logic       alarm_armed,
    input  logic       snooze_p,
    input  logic       stop_p,
    output logic       buzzer_en,
    output logic       ringing,
    output logic       snoozing,
    output logic [1:0] snooze_count,
    output logic       alarm_missed
);

    localparam int unsigned INTERVAL_MAX = (RING_SECONDS > SNOOZE_SECONDS) ?
                                           RING_SECONDS : SNOOZE_SECONDS;
    localparam int unsigned CNT_W = $clog2(INTERVAL_MAX + 1);
    localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_SECONDS - 1);

`ifdef ALARM_SNOOZE_EN
    localparam logic [CNT_W-1:0] SNOOZE_LAST  = CNT_W'(SNOOZE_SECONDS - 1);
    localparam logic [1:0]       SNOOZE_LIMIT = 2'(MAX_SNOOZES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } state_t;
`else
    typedef enum logic {
        IDLE    = 1'b0,
        RINGING = 1'b1
    } state_t;
`endif

    state_t           state;
    logic [CNT_W-1:0] sec_cnt;
    logic             match;
    logic             match_q;
    logic             trigger;

    assign match = alarm_armed
                 && (cur_hour == alarm_hour)
                 && (cur_min  == alarm_min)
                 && (cur_sec  == '0);

    // Only the first cycle of a match starts an event; a held match
    // (time frozen at hh:mm:00) must not retrigger after a stop.
    assign trigger = match & ~match_q;

`ifndef ALARM_SNOOZE_EN
    logic unused_snooze;
    assign unused_snooze = snooze_p | (MAX_SNOOZES > 3);
    assign snoozing      = 1'b0;
    assign snooze_count  = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            sec_cnt      <= '0;
            match_q      <= 1'b0;
            buzzer_en    <= 1'b0;
            ringing      <= 1'b0;
            alarm_missed <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            snoozing     <= 1'b0;
            snooze_count <= '0;
`endif
        end else begin
            match_q <= match;

            if (!alarm_armed) begin
                // Disarm overrides everything; alarm_missed is kept.
                state     <= IDLE;
                sec_cnt   <= '0;
                buzzer_en <= 1'b0;
                ringing   <= 1'b0;
`ifdef ALARM_SNOOZE_EN
                snoozing     <= 1'b0;
                snooze_count <= '0;
`endif
            end else begin
                unique case (state)
                    IDLE: begin
                        sec_cnt <= '0;
                        if (stop_p) begin
                            alarm_missed <= 1'b0;
                        end
                        if (trigger) begin
                            state        <= RINGING;
                            buzzer_en    <= 1'b1;
                            ringing      <= 1'b1;
                            alarm_missed <= 1'b0;
`ifdef ALARM_SNOOZE_EN
                            snooze_count <= '0;
`endif
                        end
                    end

                    RINGING: begin
                        if (stop_p) begin
                            state        <= IDLE;
                            sec_cnt      <= '0;
                            buzzer_en    <= 1'b0;
                            ringing      <= 1'b0;
                            alarm_missed <= 1'b0;
`ifdef ALARM_SNOOZE_EN
                            snooze_count <= '0;
                        end else if (snooze_p && (snooze_count < SNOOZE_LIMIT)) begin
                            state        <= SNOOZE;
                            sec_cnt      <= '0;
                            buzzer_en    <= 1'b0;
                            ringing      <= 1'b0;
                            snoozing     <= 1'b1;
                            snooze_count <= snooze_count + 2'd1;
`endif
                        end else if (tick_1hz) begin
                            if (sec_cnt == RING_LAST) begin
                                state        <= IDLE;
                                sec_cnt      <= '0;
                                buzzer_en    <= 1'b0;
                                ringing      <= 1'b0;
                                alarm_missed <= 1'b1;
`ifdef ALARM_SNOOZE_EN
                                snooze_count <= '0;
`endif
                            end else begin
                                sec_cnt <= sec_cnt + 1'b1;
                            end
                        end
                    end

`ifdef ALARM_SNOOZE_EN
                    SNOOZE: begin
                        if (stop_p) begin
                            state        <= IDLE;
                            sec_cnt      <= '0;
                            snoozing     <= 1'b0;
                            snooze_count <= '0;
                            alarm_missed <= 1'b0;
                        end else if (tick_1hz) begin
                            if (sec_cnt == SNOOZE_LAST) begin
                                state     <= RINGING;
                                sec_cnt   <= '0;
                                buzzer_en <= 1'b1;
                                ringing   <= 1'b1;
                                snoozing  <= 1'b0;
                            end else begin
                                sec_cnt <= sec_cnt + 1'b1;
                            end
                        end
                    end
`endif

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
